ahb_lite_master: RTL and testbench

AHB-Lite initiator that turns simple command/stream requests into pipelined AHB transfers toward `ahb_sram_top` or any AHB-Lite slave. It issues SINGLE and INCR bursts of 1–16 beats, pipelines address and data phases, and honours slave wait states and two-cycle ERROR responses. It also inserts BUSY when write data stalls and splits bursts at 1 KB boundaries. It sits between a DMA/test-sequencer and the AHB bus; the slave's `hready_out` feeds back as this block's `hready` and also drives the slave's `hready_in`.

---
 rtl/ahb_lite_master.sv | 232 +++++++++++++++++++++++
 tb/tb_ahb_lite_master.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_master.sv
// AHB-Lite initiator: command/stream requests -> pipelined SINGLE/INCR transfers with BUSY, 1 KB split, ERROR abort.
// States: IDLE wait cmd | ADDR first NONSEQ pending | BURST SEQ/BUSY issuing | LAST final data phase | ERR 2nd ERROR cycle
module ahb_lite_master #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 5
) (
   input  logic              hclk,
   input  logic              hrst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [2:0]        cmd_size,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic              wd_valid,
   input  logic [DATA_W-1:0] wd_data,
   output logic              wd_ready,
   output logic              rd_valid,
   output logic              rd_last,
   output logic [DATA_W-1:0] rd_data,
   output logic              done,
   output logic              err,
   output logic              hsel,
   output logic [1:0]        htrans,
   output logic [2:0]        hburst,
   output logic [2:0]        hsize,
   output logic              hwrite,
   output logic [ADDR_W-1:0] haddr,
   output logic [DATA_W-1:0] hwdata,
   input  logic              hready,
   input  logic [1:0]        hresp,
   input  logic [DATA_W-1:0] hrdata
);

   typedef enum logic [2:0] {S_IDLE, S_ADDR, S_BURST, S_LAST, S_ERR} state_t;

   localparam logic [1:0] HT_IDLE = 2'b00;
   localparam logic [1:0] HT_BUSY = 2'b01;
   localparam logic [1:0] HT_NSEQ = 2'b10;
   localparam logic [1:0] HT_SEQ  = 2'b11;

   state_t            state_q, state_d;
   logic [1:0]        htrans_q, htrans_d;
   logic [2:0]        hburst_q, hburst_d;
   logic [2:0]        hsize_q, hsize_d;
   logic              hwrite_q, hwrite_d;
   logic [ADDR_W-1:0] haddr_q, haddr_d;
   logic [DATA_W-1:0] hwdata_q, hwdata_d;
   logic [DATA_W-1:0] wbuf_q, wbuf_d;
   logic [LEN_W-1:0]  beats_q, beats_d;
   logic              dph_q, dph_d;
   logic              hsel_q, hsel_d;
   logic              rd_valid_q, rd_valid_d;
   logic              rd_last_q, rd_last_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

   logic              wd_take;
   logic              addr_done, data_done, err_hit;
   logic [LEN_W-1:0]  len_eff;
   logic [2:0]        size_eff;
   logic [ADDR_W-1:0] next_addr;

   always_comb begin
      if (cmd_len == '0)                 len_eff = LEN_W'(1);
      else if (cmd_len > LEN_W'(16))     len_eff = LEN_W'(16);
      else                               len_eff = cmd_len;
      size_eff  = (cmd_size > 3'd2) ? 3'd2 : cmd_size;
      next_addr = haddr_q + (ADDR_W'(1) << hsize_q);
      addr_done = hready & htrans_q[1];
      data_done = hready & dph_q;
      err_hit   = dph_q & ~hready & (hresp == 2'b01);
   end

   always_comb begin
      state_d    = state_q;
      htrans_d   = htrans_q;
      hburst_d   = hburst_q;
      hsize_d    = hsize_q;
      hwrite_d   = hwrite_q;
      haddr_d    = haddr_q;
      hwdata_d   = hwdata_q;
      wbuf_d     = wbuf_q;
      beats_d    = beats_q;
      dph_d      = dph_q;
      rd_valid_d = 1'b0;
      rd_last_d  = 1'b0;
      rd_data_d  = rd_data_q;
      done_d     = 1'b0;
      err_d      = 1'b0;
      wd_take    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               state_d  = S_ADDR;
               hwrite_d = cmd_write;
               haddr_d  = cmd_addr & ~((ADDR_W'(1) << size_eff) - ADDR_W'(1));
               hsize_d  = size_eff;
               hburst_d = (len_eff == LEN_W'(1)) ? 3'b000 : 3'b001;
               beats_d  = len_eff;
               htrans_d = (!cmd_write || wd_valid) ? HT_NSEQ : HT_IDLE;
               wd_take  = cmd_write & wd_valid;
            end
         end
         S_ADDR, S_BURST: begin
            if (err_hit) begin
               state_d  = S_ERR;
               htrans_d = HT_IDLE;
            end else begin
               if (data_done) begin
                  dph_d = 1'b0;
                  if (!hwrite_q) begin
                     rd_valid_d = 1'b1;
                     rd_data_d  = hrdata;
                  end
               end
               if (addr_done) begin
                  dph_d   = 1'b1;
                  beats_d = beats_q - LEN_W'(1);
                  if (hwrite_q) hwdata_d = wbuf_q;
                  if (beats_q == LEN_W'(1)) begin
                     state_d  = S_LAST;
                     htrans_d = HT_IDLE;
                  end else begin
                     state_d = S_BURST;
                     haddr_d = next_addr;
                     if (hwrite_q && !wd_valid) begin
                        htrans_d = HT_BUSY;
                     end else begin
                        htrans_d = (next_addr[9:0] == 10'd0) ? HT_NSEQ : HT_SEQ;
                        wd_take  = hwrite_q;
                     end
                  end
               end else if (htrans_q == HT_IDLE) begin
                  // first write beat waits for its data word before leaving IDLE
                  if (wd_valid) begin
                     htrans_d = HT_NSEQ;
                     wd_take  = 1'b1;
                  end
               end else if (htrans_q == HT_BUSY && hready && wd_valid) begin
                  htrans_d = (haddr_q[9:0] == 10'd0) ? HT_NSEQ : HT_SEQ;
                  wd_take  = 1'b1;
               end
            end
         end
         S_LAST: begin
            if (err_hit) begin
               state_d = S_ERR;
            end else if (data_done) begin
               state_d = S_IDLE;
               dph_d   = 1'b0;
               done_d  = 1'b1;
               if (!hwrite_q) begin
                  rd_valid_d = 1'b1;
                  rd_last_d  = 1'b1;
                  rd_data_d  = hrdata;
               end
            end
         end
         S_ERR: begin
            if (hready) begin
               state_d  = S_IDLE;
               htrans_d = HT_IDLE;
               dph_d    = 1'b0;
               done_d   = 1'b1;
               err_d    = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (wd_take) wbuf_d = wd_data;
      hsel_d = (htrans_d != HT_IDLE) | dph_d;
   end

   always_ff @(posedge hclk or posedge hrst) begin
      if (hrst) begin
         state_q    <= S_IDLE;
         htrans_q   <= HT_IDLE;
         hburst_q   <= '0;
         hsize_q    <= '0;
         hwrite_q   <= 1'b0;
         haddr_q    <= '0;
         hwdata_q   <= '0;
         wbuf_q     <= '0;
         beats_q    <= '0;
         dph_q      <= 1'b0;
         hsel_q     <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_last_q  <= 1'b0;
         rd_data_q  <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         htrans_q   <= htrans_d;
         hburst_q   <= hburst_d;
         hsize_q    <= hsize_d;
         hwrite_q   <= hwrite_d;
         haddr_q    <= haddr_d;
         hwdata_q   <= hwdata_d;
         wbuf_q     <= wbuf_d;
         beats_q    <= beats_d;
         dph_q      <= dph_d;
         hsel_q     <= hsel_d;
         rd_valid_q <= rd_valid_d;
         rd_last_q  <= rd_last_d;
         rd_data_q  <= rd_data_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign cmd_ready = (state_q == S_IDLE);
   assign wd_ready  = wd_take;
   assign htrans    = htrans_q;
   assign hburst    = hburst_q;
   assign hsize     = hsize_q;
   assign hwrite    = hwrite_q;
   assign haddr     = haddr_q;
   assign hwdata    = hwdata_q;
   assign hsel      = hsel_q;
   assign rd_valid  = rd_valid_q;
   assign rd_last   = rd_last_q;
   assign rd_data   = rd_data_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed bench for ahb_lite_master; slave model returns ~address as read data.
module tb_ahb_lite_master;

   logic        hclk = 1'b0;
   logic        hrst;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr;
   logic [2:0]  cmd_size;
   logic [4:0]  cmd_len;
   logic        wd_valid, wd_ready;
   logic [31:0] wd_data;
   logic        rd_valid, rd_last;
   logic [31:0] rd_data;
   logic        done, err, hsel, hwrite, hready;
   logic [1:0]  htrans, hresp;
   logic [2:0]  hburst, hsize;
   logic [31:0] haddr, hwdata, hrdata;
   logic [31:0] dph_addr = 32'd0;

   int tests = 0;
   int fails = 0;
   int wr_cnt = 0;
   int done_cnt;

   ahb_lite_master #(.ADDR_W(32), .DATA_W(32), .LEN_W(5)) dut (
      .hclk(hclk), .hrst(hrst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_len(cmd_len),
      .wd_valid(wd_valid), .wd_data(wd_data), .wd_ready(wd_ready),
      .rd_valid(rd_valid), .rd_last(rd_last), .rd_data(rd_data),
      .done(done), .err(err),
      .hsel(hsel), .htrans(htrans), .hburst(hburst), .hsize(hsize),
      .hwrite(hwrite), .haddr(haddr), .hwdata(hwdata),
      .hready(hready), .hresp(hresp), .hrdata(hrdata)
   );

   always #5 hclk = ~hclk;

   always @(posedge hclk) if (hready && htrans[1]) dph_addr <= haddr;
   assign hrdata = ~dph_addr;

   always @(negedge hclk) if (wd_ready) wr_cnt = wr_cnt + 1;

   task automatic tick();
      @(posedge hclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cmd(input logic wr, input logic [31:0] a, input logic [2:0] sz, input logic [4:0] ln);
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = a;
      cmd_size  = sz;
      cmd_len   = ln;
   endtask

   initial begin
      hrst = 1'b1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_size = 0; cmd_len = 0;
      wd_valid = 0; wd_data = 0; hready = 1'b1; hresp = 2'b00;
      tick(); tick();
      chk("rst_htrans", htrans, 0);
      chk("rst_hsel", hsel, 0);
      chk("rst_haddr", haddr, 0);
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_done", {done, err, rd_valid, rd_last, wd_ready}, 0);
      hrst = 1'b0;
      tick();

      // single write
      wr_cnt = 0;
      cmd(1'b1, 32'hffff_8004, 3'd2, 5'd1);
      wd_valid = 1'b1; wd_data = 32'h8000_0001;
      tick();
      cmd_valid = 1'b0; wd_valid = 1'b0;
      chk("w1_htrans", htrans, 2'b10);
      chk("w1_haddr", haddr, 32'hffff_8004);
      chk("w1_hburst", hburst, 3'b000);
      chk("w1_ctrl", {hsel, hwrite, cmd_ready}, 3'b110);
      tick();
      chk("w1_hwdata", hwdata, 32'h8000_0001);
      chk("w1_c2", {htrans, done}, 0);
      tick();
      chk("w1_done", {done, err, cmd_ready}, 3'b101);
      chk("w1_wdready_cnt", wr_cnt, 1);
      tick();
      chk("w1_done_pulse", done, 0);

      // INCR4 read, zero wait
      cmd(1'b0, 32'hffff_8000, 3'd2, 5'd4);
      tick(); cmd_valid = 1'b0;
      chk("r4_c1", {htrans, haddr, hburst}, {2'b10, 32'hffff_8000, 3'b001});
      tick();
      chk("r4_c2", {htrans, haddr}, {2'b11, 32'hffff_8004});
      tick();
      chk("r4_c3", {htrans, haddr}, {2'b11, 32'hffff_8008});
      chk("r4_rd0", {rd_valid, rd_last, rd_data}, {2'b10, 32'h0000_7fff});
      tick();
      chk("r4_c4", {htrans, haddr}, {2'b11, 32'hffff_800c});
      chk("r4_rd1", {rd_valid, rd_last, rd_data}, {2'b10, 32'h0000_7ffb});
      tick();
      chk("r4_c5", {htrans, done}, 0);
      chk("r4_rd2", {rd_valid, rd_last, rd_data}, {2'b10, 32'h0000_7ff7});
      tick();
      chk("r4_done", {done, err}, 2'b10);
      chk("r4_rd3", {rd_valid, rd_last, rd_data}, {2'b11, 32'h0000_7ff3});
      tick();

      // INCR4 read with two wait states on beat 2
      cmd(1'b0, 32'hffff_8000, 3'd2, 5'd4);
      tick(); cmd_valid = 1'b0;
      tick();
      chk("ws_c2", {htrans, haddr}, {2'b11, 32'hffff_8004});
      tick(); hready = 1'b0;
      chk("ws_c3", {htrans, haddr}, {2'b11, 32'hffff_8008});
      tick();
      chk("ws_c4", {htrans, haddr, rd_valid}, {2'b11, 32'hffff_8008, 1'b0});
      tick(); hready = 1'b1;
      chk("ws_c5", {htrans, haddr, rd_valid}, {2'b11, 32'hffff_8008, 1'b0});
      tick();
      chk("ws_c6", {htrans, haddr}, {2'b11, 32'hffff_800c});
      chk("ws_rd1", {rd_valid, rd_data}, {1'b1, 32'h0000_7ffb});
      tick();
      chk("ws_c7", {htrans, done}, 0);
      tick();
      chk("ws_done", {done, rd_valid, rd_last, rd_data}, {3'b111, 32'h0000_7ff3});
      tick();

      // write len 3 with write-data stall before beat 2
      wr_cnt = 0;
      cmd(1'b1, 32'hffff_8000, 3'd2, 5'd3);
      wd_valid = 1'b1; wd_data = 32'h1111_1111;
      tick(); cmd_valid = 1'b0; wd_valid = 1'b0;
      chk("bz_c1", {htrans, haddr}, {2'b10, 32'hffff_8000});
      tick();
      chk("bz_c2", {htrans, haddr, hwdata}, {2'b01, 32'hffff_8004, 32'h1111_1111});
      tick();
      wd_valid = 1'b1; wd_data = 32'h2222_2222;
      chk("bz_c3", {htrans, haddr}, {2'b01, 32'hffff_8004});
      tick();
      wd_data = 32'h3333_3333;
      chk("bz_c4", {htrans, haddr}, {2'b11, 32'hffff_8004});
      tick();
      wd_valid = 1'b0;
      chk("bz_c5", {htrans, haddr, hwdata}, {2'b11, 32'hffff_8008, 32'h2222_2222});
      tick();
      chk("bz_c6", {htrans, hwdata}, {2'b00, 32'h3333_3333});
      tick();
      chk("bz_done", {done, err}, 2'b10);
      chk("bz_wdready_cnt", wr_cnt, 3);
      tick();

      // 1 KB boundary split
      cmd(1'b0, 32'h0000_03f8, 3'd2, 5'd4);
      tick(); cmd_valid = 1'b0;
      chk("kb_c1", {htrans, haddr}, {2'b10, 32'h0000_03f8});
      tick();
      chk("kb_c2", {htrans, haddr}, {2'b11, 32'h0000_03fc});
      tick();
      chk("kb_c3", {htrans, haddr}, {2'b10, 32'h0000_0400});
      tick();
      chk("kb_c4", {htrans, haddr}, {2'b11, 32'h0000_0404});
      tick(); tick();
      chk("kb_done", {done, rd_last, rd_data}, {2'b11, ~32'h0000_0404});
      tick();

      // ERROR on beat 2 of a len-4 write
      cmd(1'b1, 32'hffff_8000, 3'd2, 5'd4);
      wd_valid = 1'b1; wd_data = 32'hdead_beef;
      tick(); cmd_valid = 1'b0;
      tick();
      chk("er_c2", {htrans, haddr}, {2'b11, 32'hffff_8004});
      tick(); hready = 1'b0; hresp = 2'b01;
      chk("er_c3", {htrans, haddr}, {2'b11, 32'hffff_8008});
      tick(); hready = 1'b1;
      chk("er_c4", {htrans, haddr, done}, {2'b00, 32'hffff_8008, 1'b0});
      tick(); hresp = 2'b00; wd_valid = 1'b0;
      chk("er_done", {done, err, htrans, rd_valid}, {2'b11, 2'b00, 1'b0});
      tick();
      chk("er_after", {done, err, htrans, cmd_ready}, {4'b0000, 1'b1});
      tick();

      // len 0 and illegal size: single word read, address aligned
      cmd(1'b0, 32'hffff_8006, 3'd7, 5'd0);
      tick(); cmd_valid = 1'b0;
      chk("cl_c1", {htrans, haddr, hsize, hburst}, {2'b10, 32'hffff_8004, 3'd2, 3'b000});
      tick();
      chk("cl_c2", htrans, 2'b00);
      tick();
      chk("cl_done", {done, rd_valid, rd_last, rd_data}, {3'b111, 32'h0000_7ffb});
      tick();

      // reset mid-burst
      cmd(1'b0, 32'hffff_8000, 3'd2, 5'd4);
      tick(); cmd_valid = 1'b0;
      tick(); tick();
      #2 hrst = 1'b1;
      #1;
      chk("mr_bus", {htrans, hburst, hsize, hwrite, hsel, haddr, hwdata}, 0);
      chk("mr_out", {rd_valid, rd_last, rd_data, done, err, wd_ready, cmd_ready}, 1);
      tick(); hrst = 1'b0;
      done_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (done) done_cnt++;
      end
      chk("mr_no_done", done_cnt, 0);
      chk("mr_idle", {htrans, cmd_ready}, 3'b001);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
